tc_unit_bank: RTL and testbench
===============================

// Module: tc_unit_bank
// PURPOSE
//  Bank of TC_NUM timer/counter channels executing the PLC timer and counter instructions.
//  Produces the packed accumulated-value bus consumed by the t/c accumulator read mux,
//  plus a per-channel done vector.
//  Sits between the rung-condition/control logic (upstream) and the accumulator read mux
//  and bit-status path (downstream).
// PARAMETERS
//  TC_NUM       16  number of channels
//  TC_ACC_LEN    8  accumulated/preset width in bits
//  TC_ADDR_LEN   4  channel address width (log2 TC_NUM)
//  TICK_DIV    100  clk cycles per timer time-base tick (>=1)
// PORTS
//  clk          in   1                     system clock, rising edge
//  reset        in   1                     asynchronous, active-low reset
//  cfgWrite     in   1                     config write strobe, single cycle
//  cfgAddr      in   TC_ADDR_LEN           channel to configure
//  cfgType      in   2                     00 TON, 01 TOF, 10 RTO, 11 CTU
//  cfgPreset    in   TC_ACC_LEN            preset value
//  tcEn         in   TC_NUM                per-channel rung condition (timer run / count input)
//  tcRst        in   TC_NUM                per-channel clear of acc and done
//  tcAccumOut   out  TC_ACC_LEN*TC_NUM     packed acc values; channel k at [k*LEN +: LEN]
//  tcDone       out  TC_NUM                per-channel done bits
// BEHAVIOUR
//  - Reset (async, reset=0): all acc=0, done=0, type=TON, preset=0, prescaler=0, prevEn=0.
//  - Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the single cycle with count==TICK_DIV-1.
//    TICK_DIV=1 -> tick every cycle.
//  - All acc and done are registered and updated on the same clk edge.
//    done reflects the new acc value; there is no extra cycle of latency.
//  - Per-channel priority: tcRst > config write to that channel > type function.
//  - tcRst[k]=1: acc=0, done=0 for every type. A tick or count edge in the same cycle is ignored.
//  - cfgWrite:
//    - Preset loads at the edge.
//    - If cfgType differs from the current type: acc=0, done=0.
//    - If the type is the same: acc is kept and done is re-evaluated next cycle against the new preset.
//  - TON:
//    - en=1 and tick and acc<preset -> acc+1.
//    - done=1 when en=1 and acc==preset.
//    - en=0 -> acc=0, done=0 at the next edge.
//  - TOF:
//    - en=1 -> acc=0, done=1.
//    - en=0 and done=1 and tick -> acc+1; when acc reaches preset, done=0 and acc holds.
//  - RTO:
//    - en=1 and tick and acc<preset -> acc+1.
//    - en=0 -> acc holds.
//    - done=1 when acc>=preset; cleared only by tcRst or a type change.
//  - CTU:
//    - Rising edge of en (en=1, prevEn=0) -> acc+1, saturating at all-ones.
//    - done=1 when acc>=preset.
//    - prevEn resets to 0, so en=1 on the first cycle after reset counts one edge.
//  - Preset=0: done asserts on the first evaluating edge (TON needs en=1; RTO/CTU immediately).
//    TOF with en=0 drops done on the next tick.
//  - acc never exceeds preset for timers and never wraps for counters.
//  - A preset lowered below the current acc leaves acc unchanged; done=1 for RTO/CTU.
//  - prevEn is updated every cycle for all channels regardless of type.
// CONFIGURATION
//  TC_IRQ_EN defined:
//    - Adds output tcIrq (1 bit), a one-cycle pulse the edge after any tcDone bit rises 0->1.
//    - Adds tcIrqSrc (TC_ADDR_LEN bits): lowest-numbered channel that rose; held until the next pulse.
//    - Both reset to 0.
//  TC_IRQ_EN undefined: neither port exists; the remaining behaviour is identical.
// TESTING
//  1. TICK_DIV=4, ch0 TON preset=3, en0=1 from reset release -> acc 1,2,3 on ticks; done=1 with acc=3 at clk 12; en0=0 -> acc=0, done=0 next edge.
//  2. ch1 TOF preset=2: en=1 -> done=1 acc=0; en=0 -> acc 1,2 on next two ticks; done=0 with acc=2.
//  3. ch2 RTO preset=5: run 3 ticks, en=0 for 10 ticks (acc stays 3), en=1 2 ticks -> acc=5 done=1; tcRst[2]=1 -> 0/0.
//  4. ch3 CTU preset=255: 300 en pulses -> acc saturates 255, done=1. ch4 CTU: tcRst and rising en same cycle -> acc stays 0.
//  5. cfgWrite ch0 type TON->RTO mid-count (acc=2) -> acc=0 done=0. Same-type preset 6->1 with acc=3 (RTO) -> done=1.
//  6. Assert reset mid-count with acc=7 on ch5 -> tcAccumOut=0 and tcDone=0 immediately (async). With TC_IRQ_EN: ch3 and ch7 done rise same edge -> tcIrq pulse, tcIrqSrc=3.

Source files
------------

// File: rtl/tc_unit_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : tc_unit_bank_if
// Brief   : Config/rung/status bundle between control logic and the timer bank.
//           Optional tcIrq/tcIrqSrc exist only when TC_IRQ_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
interface tc_unit_bank_if #(
  parameter int TC_NUM      = 16,
  parameter int TC_ACC_LEN  = 8,
  parameter int TC_ADDR_LEN = 4
);
  logic                         cfgWrite;
  logic [TC_ADDR_LEN-1:0]       cfgAddr;
  logic [1:0]                   cfgType;
  logic [TC_ACC_LEN-1:0]        cfgPreset;
  logic [TC_NUM-1:0]            tcEn;
  logic [TC_NUM-1:0]            tcRst;
  logic [TC_ACC_LEN*TC_NUM-1:0] tcAccumOut;
  logic [TC_NUM-1:0]            tcDone;
`ifdef TC_IRQ_EN
  logic                         tcIrq;
  logic [TC_ADDR_LEN-1:0]       tcIrqSrc;

  modport master (
    output cfgWrite, cfgAddr, cfgType, cfgPreset, tcEn, tcRst,
    input  tcAccumOut, tcDone, tcIrq, tcIrqSrc
  );
  modport slave (
    input  cfgWrite, cfgAddr, cfgType, cfgPreset, tcEn, tcRst,
    output tcAccumOut, tcDone, tcIrq, tcIrqSrc
  );
`else
  modport master (
    output cfgWrite, cfgAddr, cfgType, cfgPreset, tcEn, tcRst,
    input  tcAccumOut, tcDone
  );
  modport slave (
    input  cfgWrite, cfgAddr, cfgType, cfgPreset, tcEn, tcRst,
    output tcAccumOut, tcDone
  );
`endif
endinterface
`default_nettype wire

// File: rtl/tc_unit_bank.sv
`default_nettype none
// ============================================================================
// Module  : tc_unit_bank
// Brief   : Bank of TC_NUM PLC timer/counter channels (TON/TOF/RTO/CTU) sharing
//           one time-base prescaler. Define TC_IRQ_EN to add the done-rise IRQ.
// Revision: 1.0  initial release
// ============================================================================
module tc_unit_bank #(
  parameter int TC_NUM      = 16,
  parameter int TC_ACC_LEN  = 8,
  parameter int TC_ADDR_LEN = 4,
  parameter int TICK_DIV    = 100
) (
  input  logic           clk,
  input  logic           reset,
  tc_unit_bank_if.slave  bus
);

  localparam logic [1:0] c_TON = 2'b00;
  localparam logic [1:0] c_TOF = 2'b01;
  localparam logic [1:0] c_RTO = 2'b10;
  localparam logic [1:0] c_CTU = 2'b11;

  localparam int                 c_PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);

  logic [c_PRE_W-1:0]           r_preCnt;
  logic                         w_tick;
  logic [TC_NUM-1:0]            r_prevEn;
  logic [TC_NUM-1:0]            w_done;
  logic [TC_ACC_LEN*TC_NUM-1:0] w_accBus;

  assign w_tick = (r_preCnt == c_PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_preCnt <= '0;
      r_prevEn <= '0;
    end else begin
      r_preCnt <= w_tick ? '0 : r_preCnt + c_PRE_W'(1);
      r_prevEn <= bus.tcEn;
    end
  end

  for (genvar k = 0; k < TC_NUM; k++) begin : g_chan
    logic [1:0]            r_type;
    logic [TC_ACC_LEN-1:0] r_preset;
    logic [TC_ACC_LEN-1:0] r_acc;
    logic                  r_done;
    logic [TC_ACC_LEN-1:0] w_accNext;
    logic                  w_doneNext;
    logic                  w_cfgHit;
    logic                  w_en;
    logic                  w_belowPreset;

    assign w_en          = bus.tcEn[k];
    assign w_cfgHit      = bus.cfgWrite && (bus.cfgAddr == TC_ADDR_LEN'(k));
    assign w_belowPreset = (r_acc < r_preset);

    // done is derived from w_accNext so it lands on the same edge as the acc update
    always_comb begin
      w_accNext  = r_acc;
      w_doneNext = r_done;
      if (bus.tcRst[k]) begin
        w_accNext  = '0;
        w_doneNext = 1'b0;
      end else if (w_cfgHit) begin
        if (bus.cfgType != r_type) begin
          w_accNext  = '0;
          w_doneNext = 1'b0;
        end
      end else begin
        case (r_type)
          c_TON: begin
            if (!w_en) begin
              w_accNext  = '0;
              w_doneNext = 1'b0;
            end else begin
              if (w_tick && w_belowPreset) w_accNext = r_acc + TC_ACC_LEN'(1);
              w_doneNext = (w_accNext == r_preset);
            end
          end
          c_TOF: begin
            if (w_en) begin
              w_accNext  = '0;
              w_doneNext = 1'b1;
            end else if (r_done && w_tick) begin
              if (w_belowPreset) w_accNext = r_acc + TC_ACC_LEN'(1);
              w_doneNext = (w_accNext < r_preset);
            end
          end
          c_RTO: begin
            if (w_en && w_tick && w_belowPreset) w_accNext = r_acc + TC_ACC_LEN'(1);
            w_doneNext = r_done | (w_accNext >= r_preset);
          end
          c_CTU: begin
            if (w_en && !r_prevEn[k] && (r_acc != {TC_ACC_LEN{1'b1}}))
              w_accNext = r_acc + TC_ACC_LEN'(1);
            w_doneNext = (w_accNext >= r_preset);
          end
          default: begin
            w_accNext  = r_acc;
            w_doneNext = r_done;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_type   <= c_TON;
        r_preset <= '0;
        r_acc    <= '0;
        r_done   <= 1'b0;
      end else begin
        r_acc  <= w_accNext;
        r_done <= w_doneNext;
        if (w_cfgHit && !bus.tcRst[k]) begin
          r_type   <= bus.cfgType;
          r_preset <= bus.cfgPreset;
        end
      end
    end

    assign w_accBus[k*TC_ACC_LEN +: TC_ACC_LEN] = r_acc;
    assign w_done[k]                            = r_done;
  end

  assign bus.tcAccumOut = w_accBus;
  assign bus.tcDone     = w_done;

`ifdef TC_IRQ_EN
  logic [TC_NUM-1:0]      r_donePrev;
  logic [TC_NUM-1:0]      w_rise;
  logic [TC_ADDR_LEN-1:0] w_lowRise;
  logic                   r_irq;
  logic [TC_ADDR_LEN-1:0] r_irqSrc;

  assign w_rise = w_done & ~r_donePrev;

  // scan downward so the lowest-numbered rising channel wins
  always_comb begin
    w_lowRise = '0;
    for (int i = TC_NUM - 1; i >= 0; i--) begin
      if (w_rise[i]) w_lowRise = TC_ADDR_LEN'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_donePrev <= '0;
      r_irq      <= 1'b0;
      r_irqSrc   <= '0;
    end else begin
      r_donePrev <= w_done;
      r_irq      <= |w_rise;
      if (|w_rise) r_irqSrc <= w_lowRise;
    end
  end

  assign bus.tcIrq    = r_irq;
  assign bus.tcIrqSrc = r_irqSrc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tc_unit_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_tc_unit_bank
// Brief   : Directed bench for tc_unit_bank with a 4-cycle time base.
// Revision: 1.0  initial release
// ============================================================================
module tb_tc_unit_bank;

  localparam int          c_NUM  = 16;
  localparam int          c_LEN  = 8;
  localparam int          c_ADDR = 4;
  localparam int          c_DIV  = 4;
  localparam logic [1:0]  c_TON  = 2'b00;
  localparam logic [1:0]  c_TOF  = 2'b01;
  localparam logic [1:0]  c_RTO  = 2'b10;
  localparam logic [1:0]  c_CTU  = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   nPass = 0;
  int   nChk  = 0;
  int   tbPre;

  tc_unit_bank_if #(.TC_NUM(c_NUM), .TC_ACC_LEN(c_LEN), .TC_ADDR_LEN(c_ADDR)) bus ();

  tc_unit_bank #(
    .TC_NUM(c_NUM), .TC_ACC_LEN(c_LEN), .TC_ADDR_LEN(c_ADDR), .TICK_DIV(c_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference time base: the edge taken while tbPre==DIV-1 is a tick edge
  always @(posedge clk or negedge reset) begin
    if (!reset) tbPre <= 0;
    else        tbPre <= (tbPre == c_DIV - 1) ? 0 : tbPre + 1;
  end

  function automatic logic [c_LEN-1:0] acc(input int k);
    return bus.tcAccumOut[k*c_LEN +: c_LEN];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) begin
      nPass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tickEdge();
    while (tbPre != c_DIV - 1) cyc(1);
    cyc(1);
  endtask

  task automatic cfg(input logic [3:0] a, input logic [1:0] t, input logic [7:0] p);
    bus.cfgWrite  = 1'b1;
    bus.cfgAddr   = a;
    bus.cfgType   = t;
    bus.cfgPreset = p;
    cyc(1);
    bus.cfgWrite  = 1'b0;
  endtask

  task automatic pulse(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      bus.tcEn[k] = 1'b1;
      cyc(1);
      bus.tcEn[k] = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.cfgWrite  = 1'b0;
    bus.cfgAddr   = '0;
    bus.cfgType   = '0;
    bus.cfgPreset = '0;
    bus.tcEn      = '0;
    bus.tcRst     = '0;
    cyc(2);
    chk("reset_acc", 32'(|bus.tcAccumOut), 0);
    chk("reset_done", 32'(bus.tcDone), 0);
`ifdef TC_IRQ_EN
    chk("reset_irq", 32'(bus.tcIrq), 0);
`endif

    // TON ch0 preset 3, enabled from reset release
    reset       = 1'b1;
    bus.tcEn[0] = 1'b1;
    cfg(4'd0, c_TON, 8'd3);
    chk("ton_cfg_acc", 32'(acc(0)), 0);
    tickEdge(); chk("ton_acc1", 32'(acc(0)), 1); chk("ton_done_a1", 32'(bus.tcDone[0]), 0);
    tickEdge(); chk("ton_acc2", 32'(acc(0)), 2);
    tickEdge(); chk("ton_acc3", 32'(acc(0)), 3); chk("ton_done3", 32'(bus.tcDone[0]), 1);
    tickEdge(); chk("ton_hold", 32'(acc(0)), 3);
    bus.tcEn[0] = 1'b0;
    cyc(1);
    chk("ton_off_acc", 32'(acc(0)), 0); chk("ton_off_done", 32'(bus.tcDone[0]), 0);

    // TOF ch1 preset 2
    bus.tcEn[1] = 1'b1;
    cfg(4'd1, c_TOF, 8'd2);
    chk("tof_cfg_done", 32'(bus.tcDone[1]), 0);
    cyc(1);
    chk("tof_on_done", 32'(bus.tcDone[1]), 1); chk("tof_on_acc", 32'(acc(1)), 0);
    bus.tcEn[1] = 1'b0;
    tickEdge(); chk("tof_acc1", 32'(acc(1)), 1); chk("tof_done_a1", 32'(bus.tcDone[1]), 1);
    tickEdge(); chk("tof_acc2", 32'(acc(1)), 2); chk("tof_done_a2", 32'(bus.tcDone[1]), 0);
    tickEdge(); chk("tof_hold", 32'(acc(1)), 2);

    // RTO ch2 preset 5
    cfg(4'd2, c_RTO, 8'd5);
    bus.tcEn[2] = 1'b1;
    repeat (3) tickEdge();
    chk("rto_acc3", 32'(acc(2)), 3);
    bus.tcEn[2] = 1'b0;
    repeat (10) tickEdge();
    chk("rto_retain", 32'(acc(2)), 3); chk("rto_retain_done", 32'(bus.tcDone[2]), 0);
    bus.tcEn[2] = 1'b1;
    repeat (2) tickEdge();
    chk("rto_acc5", 32'(acc(2)), 5); chk("rto_done", 32'(bus.tcDone[2]), 1);
    tickEdge();
    chk("rto_cap", 32'(acc(2)), 5);
    bus.tcEn[2]  = 1'b0;
    bus.tcRst[2] = 1'b1;
    cyc(1);
    bus.tcRst[2] = 1'b0;
    chk("rto_rst_acc", 32'(acc(2)), 0); chk("rto_rst_done", 32'(bus.tcDone[2]), 0);

    // CTU ch3 saturation
    cfg(4'd3, c_CTU, 8'd255);
    pulse(3, 254);
    chk("ctu_254", 32'(acc(3)), 254); chk("ctu_254_done", 32'(bus.tcDone[3]), 0);
    pulse(3, 46);
    chk("ctu_sat", 32'(acc(3)), 255); chk("ctu_sat_done", 32'(bus.tcDone[3]), 1);

    // CTU ch4: clear wins over a simultaneous rising edge
    cfg(4'd4, c_CTU, 8'd3);
    bus.tcRst[4] = 1'b1;
    bus.tcEn[4]  = 1'b1;
    cyc(1);
    chk("ctu_rst_edge", 32'(acc(4)), 0);
    bus.tcRst[4] = 1'b0;
    cyc(1);
    chk("ctu_no_reedge", 32'(acc(4)), 0);
    bus.tcEn[4] = 1'b0;
    cyc(1);
    pulse(4, 1);
    chk("ctu_next_edge", 32'(acc(4)), 1);

    // CTU preset 0 is done on the first evaluating edge
    cfg(4'd6, c_CTU, 8'd0);
    cyc(1);
    chk("ctu_p0_done", 32'(bus.tcDone[6]), 1);

    // type change mid-count, then same-type preset lowering
    bus.tcEn[0] = 1'b1;
    repeat (2) tickEdge();
    chk("ch0_acc2", 32'(acc(0)), 2);
    cfg(4'd0, c_RTO, 8'd6);
    chk("retype_acc", 32'(acc(0)), 0); chk("retype_done", 32'(bus.tcDone[0]), 0);
    repeat (3) tickEdge();
    chk("rto6_acc3", 32'(acc(0)), 3);
    bus.tcEn[0] = 1'b0;
    cfg(4'd0, c_RTO, 8'd1);
    chk("relow_acc", 32'(acc(0)), 3); chk("relow_done0", 32'(bus.tcDone[0]), 0);
    cyc(1);
    chk("relow_done1", 32'(bus.tcDone[0]), 1); chk("relow_acc_kept", 32'(acc(0)), 3);

    // asynchronous reset mid-count
    cfg(4'd5, c_CTU, 8'd10);
    pulse(5, 7);
    chk("ch5_acc7", 32'(acc(5)), 7);
    reset = 1'b0;
    #1;
    chk("async_acc", 32'(|bus.tcAccumOut), 0);
    chk("async_done", 32'(bus.tcDone), 0);
    cyc(1);
    bus.tcEn  = '0;
    bus.tcRst = '0;
    reset     = 1'b1;

`ifdef TC_IRQ_EN
    cfg(4'd3, c_CTU, 8'd1);
    cfg(4'd7, c_CTU, 8'd1);
    bus.tcEn[3] = 1'b1;
    bus.tcEn[7] = 1'b1;
    cyc(1);
    chk("irq_done_rise", 32'(bus.tcDone), 32'h0088);
    chk("irq_not_yet", 32'(bus.tcIrq), 0);
    cyc(1);
    chk("irq_pulse", 32'(bus.tcIrq), 1); chk("irq_src", 32'(bus.tcIrqSrc), 3);
    cyc(1);
    chk("irq_end", 32'(bus.tcIrq), 0); chk("irq_src_held", 32'(bus.tcIrqSrc), 3);
`endif

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
`default_nettype wire
